// File: rtl/axi_pkg.sv
// Shared AXI constants, write-master state encoding and helpers.
//   AXI_BURST_*  : AWBURST encodings
//   AXI_RESP_*   : BRESP encodings
//   AXI_4K_BYTES : size of the page a burst may not cross
//   wr_state_e   : burst writer FSM states
//   clog2()      : ceil(log2(v)), used for AWSIZE and beat/byte shifts
//   resp_is_err(): 1 for SLVERR/DECERR
package axi_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int AXI_4K_BYTES = 4096;

    typedef enum logic [2:0] {IDLE, CALC, AW, W, B, DONE} wr_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic resp_is_err(input logic [1:0] resp);
        logic e;
        case (resp)
            AXI_RESP_OKAY, AXI_RESP_EXOKAY:   e = 1'b0;
            AXI_RESP_SLVERR, AXI_RESP_DECERR: e = 1'b1;
            default:                          e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/axi_burst_len_calc.sv
// Burst length calculator: burst_beats = min(remaining, cap, beats_to_4k).
//   remaining   : beats still to move in this transfer (nonzero when used)
//   addr_lo     : low 12 bits of the next burst start address (beat aligned)
//   burst_fixed : FIXED bursts use the 16-beat cap and ignore the 4 KB page
//   burst_beats : result, 1..256
module axi_burst_len_calc
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_BURST_BEATS = 16
) (
    input  logic [LEN_WIDTH-1:0] remaining,
    input  logic [11:0]          addr_lo,
    input  logic                 burst_fixed,
    output logic [8:0]           burst_beats
);

    localparam int SHIFT     = clog2(DATA_WIDTH / 8);
    localparam int CAP_INCR  = MAX_BURST_BEATS;
    localparam int CAP_FIXED = (MAX_BURST_BEATS < 16) ? MAX_BURST_BEATS : 16;
    // Common compare width: 13 bits holds 4096 (8-bit bus at a page start).
    localparam int CW        = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

    logic [12:0]   bytes_to_4k;
    logic [12:0]   beats_to_4k;
    logic [12:0]   cap;
    logic [12:0]   limit;
    logic [CW-1:0] rem_w;
    logic [CW-1:0] lim_w;

    always_comb begin
        bytes_to_4k = 13'(AXI_4K_BYTES) - {1'b0, addr_lo};
        beats_to_4k = bytes_to_4k >> SHIFT;
        cap         = burst_fixed ? 13'(CAP_FIXED) : 13'(CAP_INCR);
        limit       = (!burst_fixed && (beats_to_4k < cap)) ? beats_to_4k : cap;
        rem_w       = CW'(remaining);
        lim_w       = CW'(limit);
        // Both candidates are <= 256 whenever selected, so 9 bits suffice.
        burst_beats = (rem_w < lim_w) ? rem_w[8:0] : lim_w[8:0];
    end

endmodule

// File: rtl/axi_master_burst_writer.sv
// AXI write master: splits a DMA transfer of total_beats beats into legal
// bursts (beat cap, 4 KB page), one burst outstanding at a time.
//   clk, rst           : clock, synchronous active-high reset
//   start/target_addr/total_beats/burst_fixed : command, taken when idle
//   busy, done, err    : status; err is sticky over the transfer
//   fifo_rdata/fifo_rempty/fifo_rpull : FWFT FIFO read port
//   AW*, W*, B*        : AXI write address, data and response channels
module axi_master_burst_writer
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_BURST_BEATS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   target_addr,
    input  logic [LEN_WIDTH-1:0]    total_beats,
    input  logic                    burst_fixed,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    input  logic [DATA_WIDTH-1:0]   fifo_rdata,
    input  logic                    fifo_rempty,
    output logic                    fifo_rpull,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [7:0]              AWLEN,
    output logic [2:0]              AWSIZE,
    output logic [1:0]              AWBURST,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WLAST,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY
);

    localparam int SHIFT = clog2(DATA_WIDTH / 8);

    wr_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [8:0]            burst_beats_q, burst_beats_d;
    logic [8:0]            beat_cnt_q, beat_cnt_d;
    logic                  fixed_q, fixed_d;
    logic                  err_q, err_d;

    logic [8:0]            calc_beats;
    logic                  w_hs;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] burst_bytes;

    axi_burst_len_calc #(
        .DATA_WIDTH      (DATA_WIDTH),
        .LEN_WIDTH       (LEN_WIDTH),
        .MAX_BURST_BEATS (MAX_BURST_BEATS)
    ) u_len_calc (
        .remaining   (rem_q),
        .addr_lo     (addr_q[11:0]),
        .burst_fixed (fixed_q),
        .burst_beats (calc_beats)
    );

    assign w_hs        = WVALID && WREADY;
    assign last_beat   = (beat_cnt_q == (burst_beats_q - 9'd1));
    assign burst_bytes = ADDR_WIDTH'(burst_beats_q) << SHIFT;

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            rem_q         <= '0;
            burst_beats_q <= '0;
            beat_cnt_q    <= '0;
            fixed_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            burst_beats_q <= burst_beats_d;
            beat_cnt_q    <= beat_cnt_d;
            fixed_q       <= fixed_d;
            err_q         <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (total_beats != '0) ? CALC : DONE;
            CALC: state_d = AW;
            AW:   if (AWREADY) state_d = W;
            W:    if (w_hs && last_beat) state_d = B;
            B:    if (BVALID) state_d = (rem_q == '0) ? DONE : CALC;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates.
    always_comb begin
        addr_d        = addr_q;
        rem_d         = rem_q;
        burst_beats_d = burst_beats_q;
        beat_cnt_d    = beat_cnt_q;
        fixed_d       = fixed_q;
        err_d         = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = target_addr;
                    rem_d   = total_beats;
                    fixed_d = burst_fixed;
                    err_d   = 1'b0;
                end
            end
            CALC: begin
                burst_beats_d = calc_beats;
                beat_cnt_d    = '0;
            end
            W: begin
                if (w_hs) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    rem_d      = rem_q - 1'b1;
                end
            end
            B: begin
                if (BVALID) begin
                    err_d = err_q | resp_is_err(BRESP);
                    // FIXED bursts keep hammering the same address.
                    if (!fixed_q) addr_d = addr_q + burst_bytes;
                end
            end
            default: ;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        AWVALID = (state_q == AW);
        WVALID  = (state_q == W) && !fifo_rempty;
        WLAST   = (state_q == W) && last_beat;
        BREADY  = (state_q == B);
        busy    = (state_q == CALC) || (state_q == AW) || (state_q == W) || (state_q == B);
        done    = (state_q == DONE);
    end

    assign AWADDR     = addr_q;
    assign AWLEN      = 8'(burst_beats_q - 9'd1);
    assign AWSIZE     = 3'(SHIFT);
    assign AWBURST    = fixed_q ? AXI_BURST_FIXED : AXI_BURST_INCR;
    assign WDATA      = fifo_rdata;
    assign WSTRB      = '1;
    assign fifo_rpull = w_hs;
    assign err        = err_q;

endmodule

// File: tb/tb_axi_master_burst_writer.sv
`timescale 1ns/1ps
module tb_axi_master_burst_writer;

    localparam int AWID  = 32;
    localparam int DW    = 32;
    localparam int LW    = 16;
    localparam int MAXB  = 16;
    localparam int BYTES = DW / 8;
    localparam logic [2:0] EXP_SIZE = 3'd2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [AWID-1:0] target_addr;
    logic [LW-1:0]   total_beats;
    logic            burst_fixed;
    logic            busy, done, err;
    logic [DW-1:0]   fifo_rdata;
    logic            fifo_rempty;
    logic            fifo_rpull;
    logic [AWID-1:0] AWADDR;
    logic            AWVALID, AWREADY;
    logic [7:0]      AWLEN;
    logic [2:0]      AWSIZE;
    logic [1:0]      AWBURST;
    logic [DW-1:0]   WDATA;
    logic [BYTES-1:0] WSTRB;
    logic            WLAST, WVALID, WREADY;
    logic [1:0]      BRESP;
    logic            BVALID, BREADY;

    always #5 clk = ~clk;

    axi_master_burst_writer #(
        .ADDR_WIDTH(AWID), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAX_BURST_BEATS(MAXB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .target_addr(target_addr),
        .total_beats(total_beats), .burst_fixed(burst_fixed),
        .busy(busy), .done(done), .err(err),
        .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_rpull(fifo_rpull),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    typedef struct packed {logic [31:0] addr; logic [7:0] len; logic [1:0] burst;} aw_exp_t;
    typedef struct packed {logic [31:0] data; logic last;} w_exp_t;

    aw_exp_t    aw_q[$];
    w_exp_t     w_q[$];
    logic       done_q[$];
    logic [1:0] resp_q[$];

    int n_chk = 0, n_fail = 0;
    int exp_idx = 0, fifo_ptr = 0, b_pending = 0, aw_hold = 0;
    int rpull_cnt = 0, done_cnt = 0, aw_cnt = 0;
    time done_time = 0;
    bit rdy_rand = 0, empty_rand = 0, empty_toggle = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fdata(input int k);
        return 32'(k) * 32'h9E3779B1 + 32'h13579BDF;
    endfunction

    // Reference model: split a transfer into bursts from the addressing rules.
    task automatic plan(input logic [31:0] addr, input int beats, input bit fixed,
                        input bit rnd_resp, input int err_burst);
        logic [31:0] a;
        int rem, bi, n, room, cap;
        logic [1:0] resp;
        logic e;
        a = addr; rem = beats; bi = 0; e = 1'b0;
        cap = fixed ? ((MAXB < 16) ? MAXB : 16) : MAXB;
        while (rem > 0) begin
            n = (rem < cap) ? rem : cap;
            if (!fixed) begin
                room = (4096 - int'(a[11:0])) / BYTES;
                if (n > room) n = room;
            end
            aw_q.push_back('{addr: a, len: 8'(n - 1), burst: fixed ? 2'b00 : 2'b01});
            for (int k = 0; k < n; k++) begin
                w_q.push_back('{data: fdata(exp_idx), last: (k == n - 1)});
                exp_idx++;
            end
            if (bi == err_burst) resp = 2'b10;
            else if (rnd_resp) resp = 2'($urandom_range(0, 3));
            else resp = 2'b00;
            e = e | resp[1];
            resp_q.push_back(resp);
            if (!fixed) a = a + 32'(n * BYTES);
            rem -= n;
            bi++;
        end
        done_q.push_back(e);
    endtask

    // Slave/FIFO bookkeeping: observe handshakes away from the edge.
    always @(negedge clk) begin
        if (WVALID && WREADY) fifo_ptr++;
        if (rst) b_pending = 0;
        else begin
            if (WVALID && WREADY && WLAST) b_pending++;
            if (BVALID && BREADY) begin
                b_pending--;
                if (resp_q.size() > 0) void'(resp_q.pop_front());
            end
            if (AWVALID && aw_hold > 0) aw_hold--;
        end
    end

    // Slave/FIFO drivers.
    always @(posedge clk) begin
        #1;
        AWREADY = (aw_hold > 0) ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        WREADY  = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        BVALID  = (b_pending > 0) && (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        BRESP   = (resp_q.size() > 0) ? resp_q[0] : 2'b00;
        if (empty_toggle) fifo_rempty = ~fifo_rempty;
        else fifo_rempty = empty_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
        fifo_rdata = fdata(fifo_ptr);
    end

    // Monitor: compare DUT outputs against the scoreboard queues.
    bit          prev_stall = 0, aw_open = 0;
    logic [45:0] prev_aw;
    aw_exp_t     ae;
    w_exp_t      we;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
            aw_open    = 0;
        end else begin
            if (prev_stall)
                check("aw_stable", {AWVALID, AWADDR, AWLEN, AWBURST, AWSIZE}, {1'b1, prev_aw[44:0]});
            prev_stall = AWVALID && !AWREADY;
            prev_aw    = {AWVALID, AWADDR, AWLEN, AWBURST, AWSIZE};
            if (AWVALID && AWREADY) begin
                check("aw_one_outstanding", 64'(aw_open), 64'(0));
                if (aw_q.size() == 0) check("aw_unexpected", 64'(1), 64'(0));
                else begin
                    ae = aw_q.pop_front();
                    check("aw_addr", 64'(AWADDR), 64'(ae.addr));
                    check("aw_len", 64'(AWLEN), 64'(ae.len));
                    check("aw_burst", 64'(AWBURST), 64'(ae.burst));
                    check("aw_size", 64'(AWSIZE), 64'(EXP_SIZE));
                end
                aw_open = 1;
                aw_cnt++;
            end
            if (WVALID) begin
                check("w_after_aw", 64'(aw_open), 64'(1));
                check("w_fifo_nonempty", 64'(fifo_rempty), 64'(0));
                if (WREADY) begin
                    if (w_q.size() == 0) check("w_unexpected", 64'(1), 64'(0));
                    else begin
                        we = w_q.pop_front();
                        check("w_data", 64'(WDATA), 64'(we.data));
                        check("w_last", 64'(WLAST), 64'(we.last));
                        check("w_strb", 64'(WSTRB), 64'(4'hF));
                    end
                    if (WLAST) aw_open = 0;
                end
            end
            if (WVALID || fifo_rpull)
                check("rpull_eq_hs", 64'(fifo_rpull), 64'(WVALID && WREADY));
            if (fifo_rpull) rpull_cnt++;
            if (done) begin
                done_cnt++;
                done_time = $time;
                check("done_not_busy", 64'(busy), 64'(0));
                if (done_q.size() == 0) check("done_unexpected", 64'(1), 64'(0));
                else check("done_err", 64'(err), 64'(done_q.pop_front()));
            end
        end
    end

    task automatic flush();
        aw_q.delete(); w_q.delete(); done_q.delete(); resp_q.delete();
        exp_idx = fifo_ptr;
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the start edge.
    task automatic issue(input logic [31:0] addr, input int beats, input bit fixed,
                         input bit rnd_resp, input int err_burst);
        plan(addr, beats, fixed, rnd_resp, err_burst);
        target_addr = addr; total_beats = 16'(beats); burst_fixed = fixed; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; target_addr = $urandom; total_beats = 16'($urandom); burst_fixed = 1'($urandom);
    endtask

    task automatic wait_done(input int d0, input string name);
        int i;
        i = 0;
        while (done_cnt == d0 && i < 20000) begin
            @(posedge clk);
            i++;
        end
        check(name, 64'(done_cnt != d0), 64'(1));
        if (done_cnt == d0) begin
            rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
            flush();
        end else #1;
    endtask

    int d0, r0, a0;
    time t0;
    initial begin
        rst = 1'b1; start = 1'b0; target_addr = '0; total_beats = '0; burst_fixed = 1'b0;
        fifo_rdata = '0; fifo_rempty = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
        BVALID = 1'b0; BRESP = 2'b00;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", 64'({busy, done, err, AWVALID, WVALID, WLAST, BREADY, fifo_rpull}), 64'(0));
        @(posedge clk); #1;

        // 40 beats from 0x1000: three bursts, 40 pops; a start while busy is ignored.
        d0 = done_cnt; r0 = rpull_cnt; a0 = aw_cnt;
        issue(32'h1000, 40, 0, 0, -1);
        repeat (3) @(posedge clk);
        #1 start = 1'b1; total_beats = 16'd7; target_addr = 32'h9000;
        @(posedge clk); #1 start = 1'b0;
        wait_done(d0, "t1_done");
        check("t1_pulls", 64'(rpull_cnt - r0), 64'(40));
        check("t1_bursts", 64'(aw_cnt - a0), 64'(3));

        // 4 KB boundary split.
        d0 = done_cnt; a0 = aw_cnt;
        issue(32'h0FF8, 5, 0, 0, -1);
        wait_done(d0, "t2_done");
        check("t2_bursts", 64'(aw_cnt - a0), 64'(2));

        // FIXED.
        d0 = done_cnt;
        issue(32'h2000, 20, 1, 0, -1);
        wait_done(d0, "t3_done");

        // Single-burst minimum latency: N+3 cycles from start edge to done.
        d0 = done_cnt;
        issue(32'h1000, 4, 0, 0, -1);
        t0 = $time;
        wait_done(d0, "t4_done");
        check("t4_latency", 64'((done_time - t0) / 10), 64'(7));

        // SLVERR on second burst: sticky err, cleared by next start.
        d0 = done_cnt;
        issue(32'h3000, 40, 0, 0, 1);
        wait_done(d0, "t5_done");
        @(negedge clk);
        check("t5_err_holds", 64'(err), 64'(1));
        @(posedge clk); #1;
        d0 = done_cnt;
        issue(32'h3100, 3, 0, 0, -1);
        @(negedge clk);
        check("t5_err_cleared", 64'({err, busy}), 64'(2'b01));
        @(posedge clk); #1;
        wait_done(d0, "t5b_done");

        // AWREADY held low, FIFO empty every other cycle.
        aw_hold = 5; empty_toggle = 1;
        d0 = done_cnt;
        issue(32'h7000, 24, 0, 0, -1);
        wait_done(d0, "t6_done");
        empty_toggle = 0;

        // Randomised transfers.
        rdy_rand = 1; empty_rand = 1;
        for (int n = 0; n < 12; n++) begin
            logic [31:0] ra;
            ra = {$urandom_range(0, 1) ? 20'hFFFFF : 20'($urandom), 12'h000};
            ra[11:0] = $urandom_range(0, 1) ? (12'hF80 | 12'($urandom_range(0, 31) * 4))
                                             : 12'($urandom_range(0, 1023) * 4);
            d0 = done_cnt;
            issue(ra, $urandom_range(0, 60), 1'($urandom_range(0, 1)), 1, -1);
            wait_done(d0, "rand_done");
        end
        rdy_rand = 0; empty_rand = 0;
        repeat (2) @(posedge clk); #1;

        // Reset in the middle of burst 2, then a zero-beat transfer.
        r0 = rpull_cnt; a0 = aw_cnt;
        issue(32'h5000, 40, 0, 0, -1);
        for (int i = 0; i < 200 && (rpull_cnt - r0) < 20; i++) @(posedge clk);
        check("t7_reached_burst2", 64'(aw_cnt - a0), 64'(2));
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        flush();
        d0 = done_cnt;
        @(negedge clk);
        check("t7_after_reset", 64'({AWVALID, WVALID, WLAST, BREADY, busy, done}), 64'(0));
        repeat (4) @(posedge clk);
        check("t7_no_done", 64'(done_cnt - d0), 64'(0));
        #1;
        a0 = aw_cnt;
        issue(32'h6000, 0, 0, 0, -1);
        @(negedge clk);
        check("t7_zero_done", 64'({done, busy}), 64'(2'b10));
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        check("t7_zero_no_aw", 64'(aw_cnt - a0), 64'(0));

        check("aw_q_drained", 64'(aw_q.size()), 64'(0));
        check("w_q_drained", 64'(w_q.size()), 64'(0));
        check("done_q_drained", 64'(done_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
